// File: rtl/serial_to_parallel_arbiter.sv
// serial_to_parallel_arbiter
//
// Shares one LSB-first serial-to-parallel deserializer between n_requesters
// bit-serial sources. A source raises req, receives an exclusive one-hot
// grant, and shifts in exactly one width-bit word. Arbitration is
// round-robin and word-atomic: once granted, a source keeps the grant until
// its word is complete, whatever happens to its req line.
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous, active-high reset
//   req            per-source request to send one word
//   serial_valid   per-source bit strobe (only the granted source is used)
//   serial_data    per-source data bit   (only the granted source is used)
//   grant          registered, one-hot on the current source or all zero
//   parallel_valid registered one-cycle pulse per completed word
//   parallel_data  completed word, first accepted bit in bit 0 (held)
//   parallel_id    index of the source that sent parallel_data (held)

module serial_to_parallel_arbiter #(
  parameter int width        = 8,
  parameter int n_requesters = 4,
  localparam int id_w        = $clog2(n_requesters)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [n_requesters-1:0] req,
  input  logic [n_requesters-1:0] serial_valid,
  input  logic [n_requesters-1:0] serial_data,
  output logic [n_requesters-1:0] grant,
  output logic                    parallel_valid,
  output logic [width-1:0]        parallel_data,
  output logic [id_w-1:0]         parallel_id
);

  localparam int              CNT_W    = $clog2(width);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(width - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [id_w-1:0]  LAST_RST = id_w'(n_requesters - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Registered state
  state_t                  r_state;
  logic [n_requesters-1:0] r_grant;
  logic [id_w-1:0]         r_g;       // index of the granted source
  logic [id_w-1:0]         r_last;    // most recently granted source
  logic [CNT_W-1:0]        r_cnt;     // bits accepted so far in this word
  logic [width-1:0]        r_shift;
  logic                    r_pvalid;
  logic [width-1:0]        r_pdata;
  logic [id_w-1:0]         r_pid;

  // Next-state values
  state_t                  w_state_nxt;
  logic [n_requesters-1:0] w_grant_nxt;
  logic [id_w-1:0]         w_g_nxt;
  logic [id_w-1:0]         w_last_nxt;
  logic [CNT_W-1:0]        w_cnt_nxt;
  logic [width-1:0]        w_shift_nxt;
  logic                    w_pvalid_nxt;
  logic [width-1:0]        w_pdata_nxt;
  logic [id_w-1:0]         w_pid_nxt;

  // Arbitration results
  logic [id_w-1:0]         w_base;
  logic                    w_found;
  logic                    w_hit;
  logic [id_w-1:0]         w_win;
  logic [n_requesters-1:0] w_win_onehot;
  int                      w_scan_idx;

  assign grant          = r_grant;
  assign parallel_valid = r_pvalid;
  assign parallel_data  = r_pdata;
  assign parallel_id    = r_pid;

  // Round-robin winner search starting just after the last winner.
  // While BUSY the only arbitration that matters is at word completion,
  // where the current source becomes "last", so the scan starts from r_g.
  always_comb begin
    w_base     = (r_state == ST_BUSY) ? r_g : r_last;
    w_found    = 1'b0;
    w_hit      = 1'b0;
    w_win      = '0;
    w_scan_idx = 0;
    for (int k = 1; k <= n_requesters; k++) begin
      w_scan_idx = (int'(w_base) + k) % n_requesters;
      w_hit      = !w_found && req[id_w'(w_scan_idx)];
      w_win      = w_hit ? id_w'(w_scan_idx) : w_win;
      w_found    = w_found | w_hit;
    end
  end

  // One-hot form of the winner index.
  always_comb begin
    w_win_onehot        = '0;
    w_win_onehot[w_win] = 1'b1;
  end

  // Next-state logic: arbitration, bit acceptance and word completion.
  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_g_nxt      = r_g;
    w_last_nxt   = r_last;
    w_cnt_nxt    = r_cnt;
    w_shift_nxt  = r_shift;
    w_pvalid_nxt = 1'b0;
    w_pdata_nxt  = r_pdata;
    w_pid_nxt    = r_pid;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt = ST_BUSY;
          w_grant_nxt = w_win_onehot;
          w_g_nxt     = w_win;
        end else begin
          w_state_nxt = ST_IDLE;
          w_grant_nxt = '0;
        end
      end
      ST_BUSY: begin
        if (serial_valid[r_g]) begin
          w_shift_nxt[r_cnt] = serial_data[r_g];
          if (r_cnt == CNT_MAX) begin
            // Final bit: publish the word and re-arbitrate on this same
            // edge so back-to-back words have no idle cycle between them.
            w_pvalid_nxt = 1'b1;
            w_pdata_nxt  = w_shift_nxt;
            w_pid_nxt    = r_g;
            w_cnt_nxt    = '0;
            w_last_nxt   = r_g;
            if (w_found) begin
              w_state_nxt = ST_BUSY;
              w_grant_nxt = w_win_onehot;
              w_g_nxt     = w_win;
            end else begin
              w_state_nxt = ST_IDLE;
              w_grant_nxt = '0;
            end
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end else begin
          // Gap cycle: nothing moves.
          w_cnt_nxt = r_cnt;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_grant  <= '0;
      r_g      <= '0;
      r_last   <= LAST_RST;
      r_cnt    <= '0;
      r_shift  <= '0;
      r_pvalid <= 1'b0;
      r_pdata  <= '0;
      r_pid    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_g      <= w_g_nxt;
      r_last   <= w_last_nxt;
      r_cnt    <= w_cnt_nxt;
      r_shift  <= w_shift_nxt;
      r_pvalid <= w_pvalid_nxt;
      r_pdata  <= w_pdata_nxt;
      r_pid    <= w_pid_nxt;
    end
  end

endmodule

// File: doc/serial_to_parallel_arbiter.md
# serial_to_parallel_arbiter

Shares one serial-to-parallel deserializer between `n_requesters` independent serial sources. Each source raises a request, receives an exclusive one-hot grant, and shifts in exactly one `width`-bit word. The block outputs that word together with the id of the source that sent it. Arbitration is round-robin and word-atomic. The block sits between several bit-serial producers and a single word-wide consumer.

## Interface

Parameters:
- `width`, 8, bits per word; must be ≥ 2.
- `n_requesters`, 4, number of serial sources; must be ≥ 2.
- `id_w`, `$clog2(n_requesters)`, width of `parallel_id` (derived localparam).

Ports:
- `clk`  input  1  clock. All logic is on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `req`  input  `n_requesters`  per-source request to send one word.
- `serial_valid`  input  `n_requesters`  per-source bit strobe.
- `serial_data`  input  `n_requesters`  per-source data bit.
- `grant`  output  `n_requesters`  registered; one-hot or zero.
- `parallel_valid`  output  1  registered; one-cycle pulse per completed word.
- `parallel_data`  output  `width`  completed word; the first accepted bit is bit 0.
- `parallel_id`  output  `id_w`  index of the source that sent `parallel_data`.

## Operation

- **States:** IDLE (grant == 0) and BUSY (exactly one grant bit set).
- **IDLE:** at an edge where `req != 0`, the block selects a winner and enters BUSY with `grant` one-hot on the winner. At an edge where `req == 0`, it stays in IDLE.
- **Round-robin selection:**
  - The block scans `req` starting at index `(last + 1) mod n_requesters`, ascending with wrap-around.
  - `last` is the index of the most recently granted source.
  - After reset, `last = n_requesters - 1`, so requester 0 has first priority.
  - The same source may win again if it is the only requester.
- **BUSY, bit acceptance:**
  - A bit is accepted at an edge where `serial_valid[g]` is 1, where `g` is the granted index.
  - The bit `serial_data[g]` goes into shift position `cnt`, then `cnt` increments.
  - `serial_valid` and `serial_data` from non-granted sources are ignored entirely.
- **Gaps:** `serial_valid[g] == 0` cycles may occur at any time. They add latency and have no other effect.
- **Grant hold:** the grant is held until `width` bits have been accepted. Deassertion of `req[g]` mid-word is ignored, so the grant is not revoked. `req` is sampled only when arbitrating.
- **Word completion:** at the edge that accepts bit `width-1`, all of the following happen at once:
  - `parallel_valid` is set to 1.
  - The full word is loaded into `parallel_data`.
  - `g` is loaded into `parallel_id`.
  - `cnt` returns to 0 and `last` is set to `g`.
  - Re-arbitration uses `req` sampled at this same edge. `grant` moves directly to the next winner, or to 0 (IDLE) if `req == 0`. There is no idle cycle between back-to-back words.
- **Held outputs:** `parallel_data` and `parallel_id` hold their value until the next completion. `parallel_valid` is 1 for exactly one cycle per word.
- **Counter width:** `cnt` is `$clog2(width)` bits. It never exceeds `width-1`.
- **Reset:**
  - Outputs: `grant = 0`, `parallel_valid = 0`, `parallel_data = 0`, `parallel_id = 0`.
  - Internal: `cnt = 0`, `last = n_requesters - 1`.
  - Reset mid-word discards the partial word with no output.

## Timing

- **Grant latency:** `req` is first seen high at edge E0 in IDLE, and `grant` is high after E0. The first bit can be accepted at edge E1.
- **Minimum word time:** with `serial_valid` continuous from E1, the last bit is accepted at edge E`width`. `parallel_valid` is high for the cycle following E`width`.
- **Throughput:** with continuous valid and continuous requests, the block delivers one word every `width` cycles.
- **Output latency:** `parallel_valid` follows the accepting edge of the final bit by one edge (registered). There is no combinational path from inputs to outputs.
- **Sources:** must drive `serial_valid` only while their `grant` bit is visible. Bits presented in the same cycle that `grant` rises are valid, because `grant` is registered.

## Test plan

- **Single word, LSB-first:** requester 0 requests, then drives bits 1,0,1,1,0,0,0,0 on consecutive cycles after grant -> one `parallel_valid` pulse with `parallel_data = 8'h0D` and `parallel_id = 0`, one cycle after the 8th bit; `grant` returns to 0.
- **Fairness:** all four `req` held high, each source streaming continuously -> grant order 0,1,2,3,0,1. Each word is 8 cycles. Pulses occur every 8 cycles with `parallel_id` 0,1,2,3,0,1 and no idle cycle between words.
- **Gaps and isolation:** requester 2 is granted with random `serial_valid` gaps. Requesters 0, 1 and 3 toggle `serial_valid` and `serial_data` randomly -> the word equals requester 2's accepted bits only, and `parallel_id = 2`.
- **Request dropped mid-word:** requester 1 deasserts `req` after 3 bits and continues sending bits -> grant is held, the word completes normally, `parallel_id = 1`.
- **Reset mid-word:** `rst` is pulsed after 5 of 8 bits, then requester 3 sends a fresh word of 8'hA5 -> the partial word is never output. The fresh word `parallel_data = 8'hA5` is output, and the first grant after reset goes to the lowest-index active requester.
- **Scoreboard:** per-source bit queues as in the existing deserializer bench, 1000 random words -> every output matches the queue of its `parallel_id`, and total bits accepted equals `width` × number of `parallel_valid` pulses.
